// File: rtl/riscv_mem_sched.sv
// riscv_mem_sched: arbitrates the I$ and D$ miss ports onto one tagged memory
// request port and tracks in-flight requests per requester.
// Optional build macro RISCV_MEM_SCHED_ANTISTARVE_EN adds a D$ starvation
// counter that lets a waiting D$ request override the fixed I$ priority.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module riscv_mem_sched #(
    parameter int unsigned MAX_OUTST    = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ic_mem_req_valid,
    output logic                      ic_mem_req_ready,
    input  logic [`MEM_ADDR_BITS-1:0] ic_mem_req_addr,
    output logic                      ic_mem_resp_valid,
    input  logic                      dc_mem_req_valid,
    output logic                      dc_mem_req_ready,
    input  logic                      dc_mem_req_rw,
    input  logic [`MEM_ADDR_BITS-1:0] dc_mem_req_addr,
    output logic                      dc_mem_resp_valid,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_rw,
    output logic [`MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic [`MEM_TAG_BITS-1:0]  mem_req_tag,
    input  logic                      mem_resp_valid,
    input  logic [`MEM_TAG_BITS-1:0]  mem_resp_tag,
    output logic                      sched_err
);

    localparam int unsigned TW = `MEM_TAG_BITS;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);
    localparam logic [TW-1:0] TAG_IC  = TW'(0);
    localparam logic [TW-1:0] TAG_DC  = TW'(1);

    // Reject parameter values outside the supported range at elaboration.
    if (MAX_OUTST < 1 || MAX_OUTST > 7) begin : g_bad_outst
        $error("MAX_OUTST out of range 1..7");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("STARVE_LIMIT out of range 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_IC = 2'd1,
        HOLD_DC = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] ic_cnt;
    logic [CW-1:0] dc_cnt;
    logic          ic_elig;
    logic          dc_elig;
    logic          dc_starved;
    logic          grant_ic;
    logic          grant_dc;
    logic          ic_hs;
    logic          dc_hs;
    logic          ic_rsp;
    logic          dc_rsp;

    assign ic_elig = ic_mem_req_valid && (ic_cnt < MAX_CNT);
    assign dc_elig = dc_mem_req_valid && (dc_cnt < MAX_CNT);

`ifdef RISCV_MEM_SCHED_ANTISTARVE_EN
    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;

    // Count cycles an eligible D$ request is passed over; saturate at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (dc_hs) begin
            starve_cnt <= '0;
        end else if (dc_elig && (starve_cnt < STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign dc_starved = (starve_cnt >= STARVE_MAX);
`else
    assign dc_starved = 1'b0;
`endif

    // Grant selection and next state; a held grant is never re-arbitrated.
    always_comb begin
        grant_ic  = 1'b0;
        grant_dc  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dc_elig && dc_starved) begin
                    grant_dc = 1'b1;
                end else if (ic_elig) begin
                    grant_ic = 1'b1;
                end else if (dc_elig) begin
                    grant_dc = 1'b1;
                end
                if (!mem_req_ready) begin
                    if (grant_ic) begin
                        state_nxt = HOLD_IC;
                    end else if (grant_dc) begin
                        state_nxt = HOLD_DC;
                    end
                end
            end
            HOLD_IC: begin
                grant_ic = ic_mem_req_valid;
                if (!ic_mem_req_valid || mem_req_ready) begin
                    state_nxt = IDLE;
                end
            end
            HOLD_DC: begin
                grant_dc = dc_mem_req_valid;
                if (!dc_mem_req_valid || mem_req_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        grant_ic = grant_ic & reset_n;
        grant_dc = grant_dc & reset_n;
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign mem_req_valid     = grant_ic | grant_dc;
    assign mem_req_rw        = grant_dc & dc_mem_req_rw;
    assign mem_req_addr      = grant_dc ? dc_mem_req_addr : ic_mem_req_addr;
    assign mem_req_tag       = grant_dc ? TAG_DC : TAG_IC;
    assign ic_mem_req_ready  = mem_req_ready & grant_ic;
    assign dc_mem_req_ready  = mem_req_ready & grant_dc;
    assign ic_hs             = ic_mem_req_ready;
    assign dc_hs             = dc_mem_req_ready;
    assign ic_rsp            = mem_resp_valid && (mem_resp_tag == TAG_IC);
    assign dc_rsp            = mem_resp_valid && (mem_resp_tag == TAG_DC);
    assign ic_mem_resp_valid = ic_rsp;
    assign dc_mem_resp_valid = dc_rsp;

    // In-flight counters; a simultaneous issue and return cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ic_cnt <= '0;
            dc_cnt <= '0;
        end else begin
            if (ic_hs && !ic_rsp) begin
                ic_cnt <= ic_cnt + CW'(1);
            end else if (ic_rsp && !ic_hs && (ic_cnt != '0)) begin
                ic_cnt <= ic_cnt - CW'(1);
            end
            if (dc_hs && !dc_rsp) begin
                dc_cnt <= dc_cnt + CW'(1);
            end else if (dc_rsp && !dc_hs && (dc_cnt != '0)) begin
                dc_cnt <= dc_cnt - CW'(1);
            end
        end
    end

    // Sticky flag for a response that no request accounts for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sched_err <= 1'b0;
        end else if ((ic_rsp && (ic_cnt == '0)) || (dc_rsp && (dc_cnt == '0))) begin
            sched_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_mem_sched.sv
// Testbench for riscv_mem_sched: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the scheduler.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module tb_riscv_mem_sched;

    localparam int AW    = `MEM_ADDR_BITS;
    localparam int TW    = `MEM_TAG_BITS;
    localparam int MAX   = 2;
    localparam int LIMIT = 4;
`ifdef RISCV_MEM_SCHED_ANTISTARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          ic_mem_req_valid;
    logic          ic_mem_req_ready;
    logic [AW-1:0] ic_mem_req_addr;
    logic          ic_mem_resp_valid;
    logic          dc_mem_req_valid;
    logic          dc_mem_req_ready;
    logic          dc_mem_req_rw;
    logic [AW-1:0] dc_mem_req_addr;
    logic          dc_mem_resp_valid;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag;
    logic          mem_resp_valid;
    logic [TW-1:0] mem_resp_tag;
    logic          sched_err;

    riscv_mem_sched #(.MAX_OUTST(MAX), .STARVE_LIMIT(LIMIT)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ic_mem_req_valid  (ic_mem_req_valid),
        .ic_mem_req_ready  (ic_mem_req_ready),
        .ic_mem_req_addr   (ic_mem_req_addr),
        .ic_mem_resp_valid (ic_mem_resp_valid),
        .dc_mem_req_valid  (dc_mem_req_valid),
        .dc_mem_req_ready  (dc_mem_req_ready),
        .dc_mem_req_rw     (dc_mem_req_rw),
        .dc_mem_req_addr   (dc_mem_req_addr),
        .dc_mem_resp_valid (dc_mem_resp_valid),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_req_tag       (mem_req_tag),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_tag      (mem_resp_tag),
        .sched_err         (sched_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: who owns a stalled request, in-flight counts, wait age.
    int m_hold;     // 0 nobody, 1 I$ stalled on the bus, 2 D$ stalled
    int m_ic_cnt;
    int m_dc_cnt;
    int m_starve;
    bit m_err;

    // Predicted outputs for the current inputs.
    bit          e_valid, e_rw, e_ic_rdy, e_dc_rdy, e_ic_rsp, e_dc_rsp, e_err;
    logic [AW-1:0] e_addr;
    logic [TW-1:0] e_tag;
    int          e_who;
    bit          e_dc_ok;

    function automatic void model_reset();
        m_hold = 0; m_ic_cnt = 0; m_dc_cnt = 0; m_starve = 0; m_err = 1'b0;
    endfunction

    function automatic void predict();
        bit ic_ok;
        ic_ok   = ic_mem_req_valid && (m_ic_cnt < MAX);
        e_dc_ok = dc_mem_req_valid && (m_dc_cnt < MAX);
        if (m_hold == 1)                                e_who = ic_mem_req_valid ? 1 : 0;
        else if (m_hold == 2)                           e_who = dc_mem_req_valid ? 2 : 0;
        else if (e_dc_ok && ANTI && m_starve >= LIMIT)  e_who = 2;
        else if (ic_ok)                                 e_who = 1;
        else if (e_dc_ok)                               e_who = 2;
        else                                            e_who = 0;
        if (!reset_n) e_who = 0;
        e_valid  = (e_who != 0);
        e_rw     = (e_who == 2) ? dc_mem_req_rw : 1'b0;
        e_addr   = (e_who == 2) ? dc_mem_req_addr : ic_mem_req_addr;
        e_tag    = (e_who == 2) ? TW'(1) : TW'(0);
        e_ic_rdy = (e_who == 1) && mem_req_ready;
        e_dc_rdy = (e_who == 2) && mem_req_ready;
        e_ic_rsp = mem_resp_valid && (mem_resp_tag == TW'(0));
        e_dc_rsp = mem_resp_valid && (mem_resp_tag == TW'(1));
        e_err    = m_err;
    endfunction

    // Apply one rising edge to the model using the inputs held across it.
    function automatic void advance();
        if (!reset_n) begin
            model_reset();
            return;
        end
        predict();
        if ((e_ic_rsp && m_ic_cnt == 0) || (e_dc_rsp && m_dc_cnt == 0)) m_err = 1'b1;
        if (!(e_ic_rdy && e_ic_rsp)) begin
            if (e_ic_rdy) m_ic_cnt++;
            else if (e_ic_rsp && m_ic_cnt > 0) m_ic_cnt--;
        end
        if (!(e_dc_rdy && e_dc_rsp)) begin
            if (e_dc_rdy) m_dc_cnt++;
            else if (e_dc_rsp && m_dc_cnt > 0) m_dc_cnt--;
        end
        if (e_dc_rdy) m_starve = 0;
        else if (e_dc_ok && m_starve < LIMIT) m_starve++;
        m_hold = (e_who != 0 && !mem_req_ready) ? e_who : 0;
    endfunction

    function automatic logic [5:0] ctl_obs();
        return {mem_req_valid, ic_mem_req_ready, dc_mem_req_ready,
                ic_mem_resp_valid, dc_mem_resp_valid, sched_err};
    endfunction
    function automatic logic [5:0] ctl_exp();
        return {e_valid, e_ic_rdy, e_dc_rdy, e_ic_rsp, e_dc_rsp, e_err};
    endfunction
    function automatic logic [AW+TW:0] pay_obs();
        return {mem_req_rw, mem_req_addr, mem_req_tag};
    endfunction
    function automatic logic [AW+TW:0] pay_exp();
        return {e_rw, e_addr, e_tag};
    endfunction

    task automatic idle_inputs();
        ic_mem_req_valid = 1'b0; ic_mem_req_addr = '0;
        dc_mem_req_valid = 1'b0; dc_mem_req_addr = '0; dc_mem_req_rw = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ic_mem_req_valid = 1'b1; dc_mem_req_valid = 1'b1; mem_req_ready = 1'b1;
            #1;
            n_chk++;
            if ({mem_req_valid, ic_mem_req_ready, dc_mem_req_ready, sched_err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d: got %b want 0000", c,
                         {mem_req_valid, ic_mem_req_ready, dc_mem_req_ready, sched_err});
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1; predict();
        n_chk++;
        if (ctl_obs() !== ctl_exp() || (e_valid && pay_obs() !== pay_exp())) begin
            n_fail++;
            $display("FAIL reset_release: ctl got %b want %b pay got %h want %h",
                     ctl_obs(), ctl_exp(), pay_obs(), pay_exp());
        end
        @(posedge clk); advance();
    endtask

    // Both requesters always valid, every handshake answered on the next cycle.
    task automatic test_fairness();
        int  last;
        bit  exp_d;
        do_reset();
        last = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ic_mem_req_valid = 1'b1; ic_mem_req_addr = AW'(32'h1000 + i * 4);
            dc_mem_req_valid = 1'b1; dc_mem_req_addr = AW'(32'h2000 + i * 4);
            dc_mem_req_rw = i[0];
            mem_req_ready = 1'b1;
            mem_resp_valid = (last != 0);
            mem_resp_tag = (last == 2) ? TW'(1) : TW'(0);
            #1; predict();
            n_chk++;
            if (ctl_obs() !== ctl_exp() || (e_valid && pay_obs() !== pay_exp())) begin
                n_fail++;
                $display("FAIL fairness_model cyc %0d: ctl got %b want %b pay got %h want %h",
                         i, ctl_obs(), ctl_exp(), pay_obs(), pay_exp());
            end
            exp_d = ANTI && ((i % 5) == 4);
            n_chk++;
            if ({ic_mem_req_ready, dc_mem_req_ready} !== {!exp_d, exp_d}) begin
                n_fail++;
                $display("FAIL fairness_seq cyc %0d: got ic/dc ready %b want %b", i,
                         {ic_mem_req_ready, dc_mem_req_ready}, {!exp_d, exp_d});
            end
            last = e_dc_rdy ? 2 : (e_ic_rdy ? 1 : 0);
            @(posedge clk); advance();
        end
    endtask

    // D$ stalls on the bus for three cycles while I$ becomes valid.
    task automatic test_hold_dc();
        logic [AW-1:0] a_d, a_i;
        logic [AW+TW+2:0] want, got;
        do_reset();
        a_d = AW'($urandom); a_i = AW'($urandom);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            dc_mem_req_valid = (c <= 4); dc_mem_req_addr = a_d; dc_mem_req_rw = 1'b1;
            ic_mem_req_valid = (c >= 2); ic_mem_req_addr = a_i;
            mem_req_ready = (c >= 4);
            #1; predict();
            n_chk++;
            if (ctl_obs() !== ctl_exp() || (e_valid && pay_obs() !== pay_exp())) begin
                n_fail++;
                $display("FAIL hold_dc_model cyc %0d: ctl got %b want %b pay got %h want %h",
                         c, ctl_obs(), ctl_exp(), pay_obs(), pay_exp());
            end
            got  = {mem_req_valid, ic_mem_req_ready, dc_mem_req_ready, mem_req_tag, mem_req_addr};
            want = (c <= 4) ? {1'b1, 1'b0, (c == 4), TW'(1), a_d}
                            : {1'b1, 1'b1, 1'b0, TW'(0), a_i};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL hold_dc_seq cyc %0d: got %h want %h", c, got, want);
            end
            @(posedge clk); advance();
        end
    endtask

    // Third I$ request blocked by the outstanding limit until a response.
    task automatic test_outstanding();
        bit exp_rdy;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ic_mem_req_valid = 1'b1; ic_mem_req_addr = AW'(32'h40 + c);
            mem_req_ready = 1'b1;
            mem_resp_valid = (c == 4); mem_resp_tag = TW'(0);
            #1; predict();
            n_chk++;
            if (ctl_obs() !== ctl_exp() || (e_valid && pay_obs() !== pay_exp())) begin
                n_fail++;
                $display("FAIL outst_model cyc %0d: ctl got %b want %b", c, ctl_obs(), ctl_exp());
            end
            exp_rdy = (c <= 2) || (c == 5);
            n_chk++;
            if ({ic_mem_req_ready, ic_mem_resp_valid} !== {exp_rdy, (c == 4)}) begin
                n_fail++;
                $display("FAIL outst_seq cyc %0d: got rdy/resp %b want %b", c,
                         {ic_mem_req_ready, ic_mem_resp_valid}, {exp_rdy, (c == 4)});
            end
            @(posedge clk); advance();
        end
    endtask

    // Handshake and response on the same cycle leave the count at one.
    task automatic test_same_cycle();
        logic [1:0] want;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            ic_mem_req_valid = 1'b1; ic_mem_req_addr = AW'(32'h80 + c);
            mem_req_ready = 1'b1;
            mem_resp_valid = (c == 2); mem_resp_tag = TW'(0);
            #1; predict();
            want = {(c != 4), (c == 2)};
            n_chk++;
            if ({ic_mem_req_ready, ic_mem_resp_valid} !== want ||
                ctl_obs() !== ctl_exp()) begin
                n_fail++;
                $display("FAIL same_cycle cyc %0d: got rdy/resp %b want %b", c,
                         {ic_mem_req_ready, ic_mem_resp_valid}, want);
            end
            @(posedge clk); advance();
        end
    endtask

    // Unknown tag is ignored; unmatched D$ response sets a sticky error.
    task automatic test_err();
        logic [2:0] want;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            mem_resp_valid = (c == 1) || (c == 3);
            mem_resp_tag = (c == 1) ? TW'(5) : TW'(1);
            #1; predict();
            want = {1'b0, (c == 3), (c >= 4)};
            n_chk++;
            if ({ic_mem_resp_valid, dc_mem_resp_valid, sched_err} !== want ||
                ctl_obs() !== ctl_exp()) begin
                n_fail++;
                $display("FAIL err_flag cyc %0d: got resp/err %b want %b", c,
                         {ic_mem_resp_valid, dc_mem_resp_valid, sched_err}, want);
            end
            @(posedge clk); advance();
        end
    endtask

    // Reset in the middle of an I$ stall with one I$ request in flight.
    task automatic test_reset_hold();
        logic [AW-1:0] a;
        do_reset();
        a = AW'($urandom);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ic_mem_req_valid = (c <= 3); ic_mem_req_addr = a + AW'(c);
            if (c == 3) ic_mem_req_addr = a + AW'(2);
            mem_req_ready = (c == 1);
            dc_mem_req_valid = (c >= 4) && (c < 5); dc_mem_req_addr = a;
            mem_resp_valid = (c == 4); mem_resp_tag = TW'(0);
            if (c == 4) reset_n = 1'b1;
            #1; predict();
            n_chk++;
            if (ctl_obs() !== ctl_exp() || (e_valid && pay_obs() !== pay_exp())) begin
                n_fail++;
                $display("FAIL rst_hold_model cyc %0d: ctl got %b want %b pay got %h want %h",
                         c, ctl_obs(), ctl_exp(), pay_obs(), pay_exp());
            end
            if (c == 3) begin
                #2; reset_n = 1'b0; model_reset();
                #1;
                n_chk++;
                if ({mem_req_valid, ic_mem_req_ready, sched_err} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rst_hold_async: got %b want 000",
                             {mem_req_valid, ic_mem_req_ready, sched_err});
                end
            end
            if (c == 4) begin
                n_chk++;
                if ({mem_req_valid, mem_req_tag, dc_mem_req_ready} !== {1'b1, TW'(1), 1'b0}) begin
                    n_fail++;
                    $display("FAIL rst_hold_idle: got %b want %b",
                             {mem_req_valid, mem_req_tag, dc_mem_req_ready}, {1'b1, TW'(1), 1'b0});
                end
            end
            if (c == 5) begin
                n_chk++;
                if (sched_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_hold_cnt: sched_err got %b want 1", sched_err);
                end
            end
            @(posedge clk); advance();
        end
    endtask

    // Random traffic with protocol-stable stalled requests and legal responses.
    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (ic_mem_req_valid && !e_ic_rdy) begin
                ic_mem_req_valid = 1'($urandom_range(0, 7) != 0);
            end else begin
                ic_mem_req_valid = 1'($urandom_range(0, 1));
                ic_mem_req_addr = AW'($urandom);
            end
            if (dc_mem_req_valid && !e_dc_rdy) begin
                dc_mem_req_valid = 1'($urandom_range(0, 7) != 0);
            end else begin
                dc_mem_req_valid = 1'($urandom_range(0, 1));
                dc_mem_req_addr = AW'($urandom);
                dc_mem_req_rw = 1'($urandom_range(0, 1));
            end
            mem_req_ready = 1'($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 7));
            mem_resp_valid = 1'b0; mem_resp_tag = TW'($urandom_range(0, 15));
            if (r < 3 && m_ic_cnt > 0) begin
                mem_resp_valid = 1'b1; mem_resp_tag = TW'(0);
            end else if (r >= 3 && r < 5 && m_dc_cnt > 0) begin
                mem_resp_valid = 1'b1; mem_resp_tag = TW'(1);
            end else if (r == 5) begin
                mem_resp_valid = 1'b1; mem_resp_tag = TW'($urandom_range(2, 15));
            end
            #1; predict();
            n_chk++;
            if (ctl_obs() !== ctl_exp() || (e_valid && pay_obs() !== pay_exp())) begin
                n_fail++;
                $display("FAIL random cyc %0d: ctl got %b want %b pay got %h want %h",
                         i, ctl_obs(), ctl_exp(), pay_obs(), pay_exp());
            end
            @(posedge clk); advance();
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_hold_dc();
        test_outstanding();
        test_same_cycle();
        test_err();
        test_reset_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mem_sched.md
RISCV_MEM_SCHED -- requirements
Module: riscv_mem_sched

Interface
REQ-001 Parameter MAX_OUTST, default 2, SHALL set the maximum in-flight memory requests per requester (1..7).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the cycles a blocked eligible D$ request waits before it gains priority (1..15).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ic_mem_req_valid in 1, ic_mem_req_ready out 1, ic_mem_req_addr in `MEM_ADDR_BITS, ic_mem_resp_valid out 1  I$ port (read only).
REQ-006 dc_mem_req_valid in 1, dc_mem_req_ready out 1, dc_mem_req_rw in 1, dc_mem_req_addr in `MEM_ADDR_BITS, dc_mem_resp_valid out 1  D$ port.
REQ-007 mem_req_valid out 1, mem_req_ready in 1, mem_req_rw out 1, mem_req_addr out `MEM_ADDR_BITS, mem_req_tag out `MEM_TAG_BITS  memory request port.
REQ-008 mem_resp_valid in 1, mem_resp_tag in `MEM_TAG_BITS  memory response port.
REQ-009 sched_err  out  1  sticky flag: a response arrived for a requester with zero requests outstanding.

Function
REQ-010 Tag encoding SHALL be I$=0, D$=1; I$ requests SHALL drive mem_req_rw=0; the D$ request SHALL pass dc_mem_req_rw through.
REQ-011 A requester SHALL be eligible only while its valid is high and its outstanding count is below MAX_OUTST.
REQ-012 FSM states SHALL be IDLE, HOLD_IC and HOLD_DC.
REQ-013 In IDLE, the grant SHALL go to I$ if I$ is eligible; the D$ SHALL take precedence when its starve counter has reached STARVE_LIMIT. With neither requester eligible, mem_req_valid SHALL be 0.
REQ-014 In IDLE with a grant and mem_req_ready=1, the handshake SHALL complete in the same cycle and the FSM SHALL stay in IDLE; with mem_req_ready=0 the FSM SHALL move to HOLD_IC or HOLD_DC.
REQ-015 In HOLD_x, the arbiter SHALL present only requester x, with addr, rw and tag stable and no re-arbitration; on the handshake it SHALL return to IDLE; if x drops valid it SHALL return to IDLE with mem_req_valid=0 that cycle.
REQ-016 ic_mem_req_ready SHALL equal mem_req_ready AND (grant=I$); dc_mem_req_ready SHALL equal mem_req_ready AND (grant=D$); both SHALL never be 1 in the same cycle.
REQ-017 Each outstanding counter (3 bits) SHALL increment on its handshake, decrement on a response with its tag, and stay unchanged when both occur in the same cycle.
REQ-018 ic/dc_mem_resp_valid SHALL equal mem_resp_valid AND tag match, combinationally (zero latency); a response with tag other than 0 or 1 SHALL be ignored.
REQ-019 A matching response while the counter is 0 SHALL leave the counter at 0 and set sched_err on the next edge; sched_err SHALL stay set until reset.
REQ-020 The starve counter (4 bits) SHALL increment each cycle the D$ is eligible but not handshaked, SHALL saturate at STARVE_LIMIT, and SHALL clear on a D$ handshake.

Reset
REQ-021 Asserting reset_n low SHALL immediately force the FSM to IDLE and clear all counters and sched_err.
REQ-022 While reset_n=0, mem_req_valid, ic_mem_req_ready and dc_mem_req_ready SHALL be 0.
REQ-023 A reset during HOLD_x or with requests in flight SHALL discard all tracking; responses after reset that match a zero counter SHALL set sched_err as in REQ-019.

Configuration
REQ-024 With RISCV_MEM_SCHED_ANTISTARVE_EN defined, the starve counter and D$ precedence of REQ-013/REQ-020 SHALL be built.
REQ-025 Without RISCV_MEM_SCHED_ANTISTARVE_EN, the counter SHALL be absent and I$ SHALL always win IDLE arbitration (fixed priority).

Verification
REQ-026 Both requesters valid continuously, mem_req_ready=1, STARVE_LIMIT=4, macro defined -> grant sequence I,I,I,I,D repeating; without the macro, all grants go to I$.
REQ-027 D$ valid, mem_req_ready=0 for 3 cycles, I$ raises valid in cycle 2 -> FSM in HOLD_DC, mem_req_tag=1 and addr stable for 3 cycles, D$ handshake in cycle 4, I$ granted next.
REQ-028 MAX_OUTST=2, three I$ requests, no responses -> third request sees ic_mem_req_ready=0; after a response with tag 0, the third request handshakes.
REQ-029 I$ handshake and tag-0 response in the same cycle with count 1 -> count stays 1; ic_mem_resp_valid=1 in that cycle.
REQ-030 Tag-1 response with D$ count 0 -> sched_err=1 next cycle and holds; tag-5 response -> no resp_valid output asserted.
REQ-031 Drop reset_n mid HOLD_IC -> mem_req_valid=0 immediately; after release, FSM is in IDLE and counts are 0.
